// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared mode encoding and default terminal values. Rev 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ============================================================================
// btn_sync_edge : 2-flop synchronizer with one-cycle rising-edge pulse. Rev 1.0
// ============================================================================
`default_nettype none

module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_pulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// clock_set_ctrl : 1 Hz time-base, carry strobes and RUN/SET mode FSM.
// Optional macro CLOCK_SET_AUTOREPEAT_EN adds inc-button auto-repeat. Rev 1.0
// ============================================================================
`default_nettype none

module clock_set_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int SEC_MAX   = clock_pkg::SEC_MAX,
  parameter int MIN_MAX   = clock_pkg::MIN_MAX,
  parameter int HR_MAX    = clock_pkg::HR_MAX,
  parameter int BLINK_DIV = 500,
  parameter int RPT_DLY   = 500,
  parameter int RPT_RATE  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [7:0] sec_val,
  input  logic [7:0] min_val,
  input  logic [7:0] hr_val,
  output logic       sec_step,
  output logic       min_step,
  output logic       hr_step,
  output logic       tick,
  output logic [1:0] mode,
  output logic       blank
);

  import clock_pkg::*;

  localparam logic [1:0] ST_RUN     = MODE_RUN;
  localparam logic [1:0] ST_SET_HR  = MODE_SET_HR;
  localparam logic [1:0] ST_SET_MIN = MODE_SET_MIN;
  localparam logic [1:0] ST_SET_SEC = MODE_SET_SEC;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic            w_mode_pulse;
  logic            w_mode_level;
  logic            w_inc_pulse;
  logic            w_inc_level;
  logic            w_in_set;
  logic            w_pre_wrap;
  logic            w_sec_last;
  logic            w_min_last;
  logic            w_inc_req;
  logic            w_set_inc;
  logic [1:0]      w_mode_next;
  logic            w_unused;

  logic [1:0]      r_mode;
  logic [PW-1:0]   r_pre;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blank;
  logic            r_tick;
  logic            r_sec_step;
  logic            r_min_step;
  logic            r_hr_step;

  btn_sync_edge u_mode_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (mode_btn),
    .o_level (w_mode_level),
    .o_pulse (w_mode_pulse)
  );

  btn_sync_edge u_inc_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (inc_btn),
    .o_level (w_inc_level),
    .o_pulse (w_inc_pulse)
  );

  assign w_in_set   = (r_mode != ST_RUN);
  assign w_pre_wrap = (r_mode == ST_RUN) && (r_pre == PRE_LAST);
  assign w_sec_last = (sec_val == 8'(SEC_MAX));
  assign w_min_last = (min_val == 8'(MIN_MAX));
  // A mode press in the same cycle swallows any increment request.
  assign w_set_inc  = w_in_set && w_inc_req && !w_mode_pulse;

  always_comb begin
    w_mode_next = ST_RUN;
    case (r_mode)
      ST_RUN:     w_mode_next = ST_SET_HR;
      ST_SET_HR:  w_mode_next = ST_SET_MIN;
      ST_SET_MIN: w_mode_next = ST_SET_SEC;
      default:    w_mode_next = ST_RUN;
    endcase
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt_armed;
  logic [RW-1:0] w_rpt_target;
  logic          w_rpt_hold;
  logic          w_rpt_fire;
  logic          w_unused_lvl;

  // The counter starts at 1 on the press edge so the first repeat lands
  // exactly RPT_DLY cycles after the press step.
  assign w_rpt_target = r_rpt_armed ? RW'(RPT_RATE) : RW'(RPT_DLY);
  assign w_rpt_hold   = w_in_set && w_inc_level && !w_mode_pulse;
  assign w_rpt_fire   = w_rpt_hold && (r_rpt_cnt == w_rpt_target);
  assign w_inc_req    = w_inc_pulse | w_rpt_fire;
  assign w_unused_lvl = w_mode_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= RW'(1);
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + RW'(1);
    end
  end
`else
  logic w_unused_rpt;

  assign w_inc_req    = w_inc_pulse;
  assign w_unused_rpt = &{1'b0, w_inc_level, w_mode_level, 16'(RPT_DLY), 16'(RPT_RATE)};
`endif

  // Hours rollover belongs to the hours counter, so its value is not needed.
  assign w_unused = &{1'b0, hr_val, 8'(HR_MAX)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= ST_RUN;
      r_pre  <= '0;
    end else begin
      if (w_mode_pulse) begin
        r_mode <= w_mode_next;
      end
      if (w_mode_pulse && (r_mode == ST_SET_SEC)) begin
        r_pre <= '0;
      end else if (r_mode == ST_RUN) begin
        r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick     <= 1'b0;
      r_sec_step <= 1'b0;
      r_min_step <= 1'b0;
      r_hr_step  <= 1'b0;
    end else begin
      r_tick     <= w_pre_wrap;
      r_sec_step <= w_pre_wrap
                 || (w_set_inc && (r_mode == ST_SET_SEC));
      r_min_step <= (w_pre_wrap && w_sec_last)
                 || (w_set_inc && (r_mode == ST_SET_MIN));
      r_hr_step  <= (w_pre_wrap && w_sec_last && w_min_last)
                 || (w_set_inc && (r_mode == ST_SET_HR));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (w_mode_pulse || !w_in_set) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blank     <= ~r_blank;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign tick     = r_tick;
  assign sec_step = r_sec_step;
  assign min_step = r_min_step;
  assign hr_step  = r_hr_step;
  assign mode     = r_mode;
  assign blank    = r_blank;

endmodule

`default_nettype wire

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-base and mode controller for the digital clock. Generates the 1 Hz tick and sequences increment strobes to the seconds, minutes and hours counters, including carry rippling.
- Runs a RUN / SET_HR / SET_MIN / SET_SEC mode FSM driven by two push-buttons.
- Sits between the button inputs and the three clock-enabled counters. Reads counter values back to decide carries.

Parameters:
- CLK_DIV, 1000, clk cycles per 1 s tick (1 ms clock).
- SEC_MAX, 59, seconds terminal value.
- MIN_MAX, 59, minutes terminal value.
- HR_MAX, 23, hours terminal value.
- BLINK_DIV, 500, clk cycles per blink half-period.
- RPT_DLY, 500, auto-repeat initial delay in cycles (optional feature only).
- RPT_RATE, 200, auto-repeat period in cycles (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_btn  in  1  asynchronous level; cycles mode.
- inc_btn  in  1  asynchronous level; increments selected field in SET modes.
- sec_val  in  8  current seconds count (binary).
- min_val  in  8  current minutes count.
- hr_val  in  8  current hours count.
- sec_step  out  1  one-cycle increment strobe to seconds counter.
- min_step  out  1  one-cycle increment strobe to minutes counter.
- hr_step  out  1  one-cycle increment strobe to hours counter.
- tick  out  1  one-cycle 1 Hz pulse (RUN only).
- mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC.
- blank  out  1  high blanks the selected display field (blink phase).

Behaviour:
- Reset (rst=0, async): mode=RUN, prescaler=0, blink counter=0, synchronizers=0. All step outputs, tick and blank = 0.
- Buttons: 2-flop synchronizer, then rising-edge detect. Each press yields one internal pulse. Press-to-action latency is 3 cycles. Debounce is out of scope (upstream).
- Prescaler counts 0..CLK_DIV-1 in RUN only. tick=1 in the cycle the count equals CLK_DIV-1, then it wraps to 0.
- RUN:
  - sec_step = tick.
  - min_step = tick && sec_val==SEC_MAX.
  - hr_step = tick && sec_val==SEC_MAX && min_val==MIN_MAX.
  - All strobes are registered and fire together in the same cycle. Hours wrap is the counter's job.
- FSM on mode press: RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- Entering SET_HR freezes the prescaler (holds its value, no tick).
- SET_SEC->RUN clears the prescaler to 0, so the first tick comes CLK_DIV cycles later.
- SET modes: an inc press pulses only the selected field's step for 1 cycle. No carry; the counter wraps itself (e.g. min 59->0, hr untouched). hr_val/min_val/sec_val are ignored.
- Simultaneous mode and inc press in the same cycle: mode wins, inc is dropped.
- blank: toggles every BLINK_DIV cycles in SET modes. Forced 0 in RUN. Blink counter clears on every mode change.
- Reset mid-operation: immediate return to RUN. No step is emitted in the reset-release cycle.
- Widths: prescaler is $clog2(CLK_DIV) bits. Comparisons are 8-bit unsigned.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- Defined:
  - In SET modes, holding synchronized inc_btn high for RPT_DLY cycles after the press issues an extra step.
  - Further steps follow every RPT_RATE cycles while held.
  - Release or a mode change cancels the repeat and clears its counter.
- Undefined: one step per press only; RPT_* parameters unused.

Decomposition:
- Package clock_pkg:
  - mode enum (RUN, SET_HR, SET_MIN, SET_SEC; 2-bit).
  - Default constants SEC_MAX, MIN_MAX, HR_MAX.
- Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, one clock, active-low async reset. Instantiated twice.

Test Plan:
- Reset then 3*CLK_DIV cycles -> tick and sec_step at cycles 1000, 2000, 3000 (±3 sync/reg offset); min_step and hr_step stay 0; blank=0.
- sec_val=59, min_val=10, at tick -> sec_step=min_step=1 in the same cycle, hr_step=0.
- sec_val=59, min_val=59 at tick -> sec_step, min_step and hr_step all 1 in the same cycle.
- mode presses 1,2,3,4 -> mode 1,2,3,0. Prescaler frozen during SET. First tick comes exactly CLK_DIV cycles after re-entering RUN. blank toggles every 500 cycles in SET.
- In SET_MIN, inc press with sec_val=59, min_val=59 -> single min_step, no hr_step, no sec_step. Same-cycle mode+inc -> mode advances, no step.
- Assert rst low mid-SET_HR with inc held -> mode=0 and all outputs 0 asynchronously. With CLOCK_SET_AUTOREPEAT_EN, a 1000-cycle hold in SET_HR yields steps at press, +500, +700, +900.
